// File: rtl/parc_rob_param_if.sv
// Bundle for the reorder buffer: allocate, fill, commit, flush and two
// register lookups. Handshakes transfer on a cycle where valid && ready are
// both high at the rising edge; ready never depends on valid in the same
// cycle, and valid may be raised or dropped freely between transfers.
interface parc_rob_param_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = 5
);
  localparam int SW = $clog2(DEPTH);

  logic          alloc_val;
  logic          alloc_rdy;
  logic          alloc_wen;
  logic [AW-1:0] alloc_waddr;
  logic [SW-1:0] alloc_slot;

  logic          fill_val;
  logic [SW-1:0] fill_slot;
  logic [DW-1:0] fill_data;

  logic          commit_val;
  logic          commit_rdy;
  logic          commit_wen;
  logic [AW-1:0] commit_waddr;
  logic [DW-1:0] commit_data;

  logic          flush;

  logic [AW-1:0] src0_addr;
  logic          src0_hit;
  logic          src0_pend;
  logic [SW-1:0] src0_slot;
  logic [DW-1:0] src0_data;
  logic [AW-1:0] src1_addr;
  logic          src1_hit;
  logic          src1_pend;
  logic [SW-1:0] src1_slot;
  logic [DW-1:0] src1_data;

  logic [SW:0]   count;
  logic          full;
  logic          empty;

  modport master (
    output alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot, fill_data,
           commit_rdy, flush, src0_addr, src1_addr,
    input  alloc_rdy, alloc_slot, commit_val, commit_wen, commit_waddr,
           commit_data, src0_hit, src0_pend, src0_slot, src0_data,
           src1_hit, src1_pend, src1_slot, src1_data, count, full, empty
  );

  modport slave (
    input  alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot, fill_data,
           commit_rdy, flush, src0_addr, src1_addr,
    output alloc_rdy, alloc_slot, commit_val, commit_wen, commit_waddr,
           commit_data, src0_hit, src0_pend, src0_slot, src0_data,
           src1_hit, src1_pend, src1_slot, src1_data, count, full, empty
  );
endinterface

// File: rtl/parc_rob_param.sv
// Parameterised reorder buffer: in-order allocate/commit, out-of-order fill,
// and two youngest-producer lookups with same-cycle fill bypass.
module parc_rob_param #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 32,
  parameter  int AW    = 5,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  parc_rob_param_if.slave rob
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] wen_q;
  logic [AW-1:0]    waddr_q [DEPTH];
  logic [DW-1:0]    data_q  [DEPTH];

  // Pointers carry one extra wrap bit so full and empty differ.
  logic [SW:0]   head_q;
  logic [SW:0]   tail_q;
  logic [SW:0]   count_w;
  logic [SW-1:0] head_idx;
  logic [SW-1:0] tail_idx;
  logic          full_w;
  logic          alloc_rdy_w;
  logic          commit_val_w;
  logic          alloc_fire;
  logic          commit_fire;
  logic          fill_ok;

  assign head_idx     = head_q[SW-1:0];
  assign tail_idx     = tail_q[SW-1:0];
  assign count_w      = tail_q - head_q;
  assign full_w       = (count_w == (SW+1)'(DEPTH));
  assign alloc_rdy_w  = !full_w && !rob.flush;
  assign commit_val_w = valid_q[head_idx] && filled_q[head_idx] && !rob.flush;
  assign alloc_fire   = rob.alloc_val && alloc_rdy_w;
  assign commit_fire  = commit_val_w && rob.commit_rdy;
  assign fill_ok      = rob.fill_val && valid_q[rob.fill_slot] && !filled_q[rob.fill_slot];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      filled_q <= '0;
      wen_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (rob.flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // Alloc, fill and commit touch distinct slots: alloc targets an
      // invalid slot, fill only a valid one, commit only the filled head.
      if (alloc_fire) begin
        valid_q[tail_idx]  <= 1'b1;
        filled_q[tail_idx] <= !rob.alloc_wen;
        wen_q[tail_idx]    <= rob.alloc_wen;
        tail_q             <= tail_q + 1'b1;
      end
      if (fill_ok) begin
        filled_q[rob.fill_slot] <= 1'b1;
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
    end
  end

  // Payload storage is never reset; every read of it is gated by valid.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      waddr_q[tail_idx] <= rob.alloc_waddr;
    end
    if (fill_ok && !rob.flush) begin
      data_q[rob.fill_slot] <= rob.fill_data;
    end
  end

  logic [AW-1:0] src_addr [2];
  logic [1:0]    src_hit;
  logic [1:0]    src_pend;
  logic [SW-1:0] src_slot [2];
  logic [DW-1:0] src_data [2];
  logic [SW-1:0] idx;

  assign src_addr[0] = rob.src0_addr;
  assign src_addr[1] = rob.src1_addr;

  // Walk oldest to youngest from head; the last match is the youngest.
  always_comb begin
    idx = '0;
    for (int n = 0; n < 2; n++) begin
      src_hit[n]  = 1'b0;
      src_pend[n] = 1'b0;
      src_slot[n] = '0;
      src_data[n] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_idx + SW'(i);
        if (valid_q[idx] && wen_q[idx] && (waddr_q[idx] == src_addr[n]) &&
            (src_addr[n] != '0)) begin
          src_hit[n]  = 1'b1;
          src_slot[n] = idx;
        end
      end
      if (src_hit[n]) begin
        if (!filled_q[src_slot[n]] && rob.fill_val && (rob.fill_slot == src_slot[n])) begin
          src_pend[n] = 1'b0;
          src_data[n] = rob.fill_data;
        end else begin
          src_pend[n] = !filled_q[src_slot[n]];
          src_data[n] = data_q[src_slot[n]];
        end
      end
    end
  end

  assign rob.alloc_rdy    = alloc_rdy_w;
  assign rob.alloc_slot   = tail_idx;
  assign rob.commit_val   = commit_val_w;
  assign rob.commit_wen   = commit_val_w && wen_q[head_idx];
  assign rob.commit_waddr = commit_val_w ? waddr_q[head_idx] : '0;
  assign rob.commit_data  = commit_val_w ? data_q[head_idx] : '0;
  assign rob.src0_hit     = src_hit[0];
  assign rob.src0_pend    = src_pend[0];
  assign rob.src0_slot    = src_slot[0];
  assign rob.src0_data    = src_data[0];
  assign rob.src1_hit     = src_hit[1];
  assign rob.src1_pend    = src_pend[1];
  assign rob.src1_slot    = src_slot[1];
  assign rob.src1_data    = src_data[1];
  assign rob.count        = count_w;
  assign rob.full         = full_w;
  assign rob.empty        = (count_w == '0);

endmodule

// File: tb/tb_parc_rob_param.sv
// Bench for parc_rob_param: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_parc_rob_param;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int SW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  parc_rob_param_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) rif ();

  parc_rob_param #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data;
    logic          filled;
    int            slot;
  } ent_t;

  ent_t exp_q[$];   // in-flight entries, oldest first
  int   m_tail;     // slot the next allocation receives
  logic e_ardy;
  logic e_cv;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic src_check(input int n, input logic [AW-1:0] a, input logic hit,
                           input logic pend, input logic [SW-1:0] slot,
                           input logic [DW-1:0] data);
    int k;
    logic byp;
    k = -1;
    if (a != '0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].wen && exp_q[i].waddr == a) begin
          k = i;
          break;
        end
      end
    end
    if (k < 0) begin
      chk($sformatf("src%0d_hit", n),  hit,  0);
      chk($sformatf("src%0d_pend", n), pend, 0);
      chk($sformatf("src%0d_slot", n), slot, 0);
      chk($sformatf("src%0d_data", n), data, 0);
    end else begin
      byp = !exp_q[k].filled && rif.fill_val && (int'(rif.fill_slot) == exp_q[k].slot);
      chk($sformatf("src%0d_hit", n),  hit,  1);
      chk($sformatf("src%0d_slot", n), slot, exp_q[k].slot);
      chk($sformatf("src%0d_pend", n), pend, !exp_q[k].filled && !byp);
      if (byp) chk($sformatf("src%0d_byp_data", n), data, rif.fill_data);
      else if (exp_q[k].filled) chk($sformatf("src%0d_data", n), data, exp_q[k].data);
    end
  endtask

  task automatic model_check();
    int n;
    n = exp_q.size();
    e_ardy = (n < DEPTH) && !rif.flush;
    e_cv   = !rif.flush && (n > 0) && exp_q[0].filled;
    chk("count",      rif.count,      n);
    chk("full",       rif.full,       n == DEPTH);
    chk("empty",      rif.empty,      n == 0);
    chk("alloc_rdy",  rif.alloc_rdy,  e_ardy);
    chk("alloc_slot", rif.alloc_slot, m_tail);
    chk("commit_val", rif.commit_val, e_cv);
    if (e_cv) begin
      chk("commit_wen",   rif.commit_wen,   exp_q[0].wen);
      chk("commit_waddr", rif.commit_waddr, exp_q[0].waddr);
      if (exp_q[0].wen) chk("commit_data", rif.commit_data, exp_q[0].data);
    end else begin
      chk("commit_wen_idle",   rif.commit_wen,   0);
      chk("commit_waddr_idle", rif.commit_waddr, 0);
      chk("commit_data_idle",  rif.commit_data,  0);
    end
    src_check(0, rif.src0_addr, rif.src0_hit, rif.src0_pend, rif.src0_slot, rif.src0_data);
    src_check(1, rif.src1_addr, rif.src1_hit, rif.src1_pend, rif.src1_slot, rif.src1_data);
  endtask

  task automatic model_step();
    if (rif.flush) begin
      exp_q.delete();
      m_tail = 0;
    end else begin
      if (rif.fill_val) begin
        foreach (exp_q[i]) begin
          if (exp_q[i].slot == int'(rif.fill_slot) && !exp_q[i].filled) begin
            exp_q[i].filled = 1'b1;
            exp_q[i].data   = rif.fill_data;
          end
        end
      end
      if (e_cv && rif.commit_rdy) void'(exp_q.pop_front());
      if (rif.alloc_val && e_ardy) begin
        ent_t e;
        e.wen    = rif.alloc_wen;
        e.waddr  = rif.alloc_waddr;
        e.data   = '0;
        e.filled = !rif.alloc_wen;
        e.slot   = m_tail;
        exp_q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  // Inputs are stable at the falling edge until after the next rising edge,
  // so the model advances here to the state after that rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_tail = 0;
    end
    model_check();
    if (reset) model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    rif.alloc_val   = 1'b0;
    rif.alloc_wen   = 1'b0;
    rif.alloc_waddr = '0;
    rif.fill_val    = 1'b0;
    rif.fill_slot   = '0;
    rif.fill_data   = '0;
    rif.commit_rdy  = 1'b0;
    rif.flush       = 1'b0;
    rif.src0_addr   = '0;
    rif.src1_addr   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic alloc(input logic wen, input logic [AW-1:0] waddr);
    rif.alloc_val   = 1'b1;
    rif.alloc_wen   = wen;
    rif.alloc_waddr = waddr;
    tick();
    rif.alloc_val = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    #1 reset = 1'b0;
    tick();
    settle();
    chk("rst_alloc_rdy",  rif.alloc_rdy,  1);
    chk("rst_alloc_slot", rif.alloc_slot, 0);
    chk("rst_commit_val", rif.commit_val, 0);
    chk("rst_count",      rif.count,      0);
    chk("rst_empty",      rif.empty,      1);
    chk("rst_full",       rif.full,       0);
    chk("rst_src0_hit",   rif.src0_hit,   0);
    reset = 1'b1;
    tick();

    // Single entry: alloc r3, fill, retire.
    rif.alloc_val = 1'b1; rif.alloc_wen = 1'b1; rif.alloc_waddr = 5'd3;
    settle();
    chk("s1_slot", rif.alloc_slot, 0);
    tick();
    idle();
    rif.fill_val = 1'b1; rif.fill_slot = '0; rif.fill_data = 32'hDEAD; rif.commit_rdy = 1'b1;
    settle();
    chk("s1_no_early_commit", rif.commit_val, 0);
    tick();
    idle();
    rif.commit_rdy = 1'b1;
    settle();
    chk("s1_cv",    rif.commit_val,   1);
    chk("s1_waddr", rif.commit_waddr, 3);
    chk("s1_data",  rif.commit_data,  32'hDEAD);
    tick();
    idle();
    settle();
    chk("s1_empty",    rif.empty,      1);
    chk("s1_cv_after", rif.commit_val, 0);

    // Youngest producer and fill bypass.
    rif.flush = 1'b1; tick(); idle();
    alloc(1'b1, 5'd5);
    alloc(1'b1, 5'd5);
    rif.src0_addr = 5'd5;
    settle();
    chk("s2_hit",  rif.src0_hit,  1);
    chk("s2_slot", rif.src0_slot, 1);
    chk("s2_pend", rif.src0_pend, 1);
    rif.fill_val = 1'b1; rif.fill_slot = 4'd1; rif.fill_data = 32'h42;
    settle();
    chk("s2_byp_pend", rif.src0_pend, 0);
    chk("s2_byp_data", rif.src0_data, 32'h42);
    tick();
    rif.fill_val = 1'b0;
    settle();
    chk("s2_filled_pend", rif.src0_pend, 0);
    chk("s2_filled_data", rif.src0_data, 32'h42);
    chk("s2_zero_miss",   rif.src1_hit,  0);
    rif.flush = 1'b1; tick(); idle();

    // Fill to capacity, no pass-through, then wrap with paired traffic.
    for (int i = 0; i < DEPTH; i++) alloc(1'b0, AW'(i));
    settle();
    chk("s3_full",  rif.full,      1);
    chk("s3_rdy",   rif.alloc_rdy, 0);
    chk("s3_count", rif.count,     DEPTH);
    rif.commit_rdy = 1'b1; rif.alloc_val = 1'b1;
    settle();
    chk("s3_cv",      rif.commit_val, 1);
    chk("s3_no_pass", rif.alloc_rdy,  0);
    tick();
    idle();
    settle();
    chk("s3_rdy_after", rif.alloc_rdy, 1);
    for (int i = 0; i < 20; i++) begin
      rif.alloc_val = 1'b1; rif.alloc_wen = 1'b0;
      rif.alloc_waddr = AW'($urandom_range(0, 31));
      rif.commit_rdy = 1'b1;
      settle();
      if (i == 0) chk("s3_order_first", rif.commit_waddr, 1);
      tick();
    end
    idle();
    settle();
    chk("s3_count_pairs", rif.count, DEPTH - 1);
    rif.flush = 1'b1; tick(); idle();

    // Out-of-order fills, in-order retire.
    for (int i = 0; i < 3; i++) alloc(1'b1, AW'(i + 1));
    rif.commit_rdy = 1'b1;
    rif.fill_val = 1'b1; rif.fill_slot = 4'd2; rif.fill_data = 32'h200;
    tick();
    rif.fill_slot = 4'd1; rif.fill_data = 32'h100;
    settle();
    chk("s4_wait_a", rif.commit_val, 0);
    tick();
    rif.fill_slot = 4'd0; rif.fill_data = 32'h0AA;
    settle();
    chk("s4_wait_b", rif.commit_val, 0);
    tick();
    rif.fill_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s4_cv",    rif.commit_val,   1);
      chk("s4_order", rif.commit_waddr, k + 1);
      tick();
    end
    idle();
    settle();
    chk("s4_empty", rif.empty, 1);

    // Flush beats a simultaneous alloc and commit.
    for (int i = 0; i < 5; i++) alloc(1'b0, AW'(i + 8));
    rif.flush = 1'b1; rif.alloc_val = 1'b1; rif.commit_rdy = 1'b1;
    settle();
    chk("s5_cv",   rif.commit_val, 0);
    chk("s5_ardy", rif.alloc_rdy,  0);
    tick();
    idle();
    settle();
    chk("s5_count", rif.count,      0);
    chk("s5_slot",  rif.alloc_slot, 0);

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 7; i++) alloc(1'b1, 5'd9);
    rif.src0_addr = 5'd9;
    settle();
    chk("s6_pre_count", rif.count, 7);
    reset = 1'b0;
    #1;
    chk("s6_count", rif.count,      0);
    chk("s6_cv",    rif.commit_val, 0);
    chk("s6_empty", rif.empty,      1);
    chk("s6_miss",  rif.src0_hit,   0);
    tick();
    reset = 1'b1;
    idle();
    tick();

    // Randomized traffic; the falling-edge model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      rif.alloc_val   = ($urandom_range(0, 3) != 0);
      rif.alloc_wen   = ($urandom_range(0, 3) != 0);
      rif.alloc_waddr = AW'($urandom_range(0, 7));
      rif.fill_val    = ($urandom_range(0, 1) != 0);
      if (exp_q.size() > 0 && $urandom_range(0, 1) != 0)
        rif.fill_slot = SW'(exp_q[$urandom_range(0, exp_q.size() - 1)].slot);
      else
        rif.fill_slot = SW'($urandom_range(0, DEPTH - 1));
      rif.fill_data   = $urandom;
      rif.commit_rdy  = (c < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rif.flush       = ($urandom_range(0, 63) == 0);
      rif.src0_addr   = AW'($urandom_range(0, 7));
      rif.src1_addr   = AW'($urandom_range(0, 7));
      if (c == 900) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parc_rob_param.md
PARC_ROB_PARAM -- requirements
Module: parc_rob_param

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 16, entry count; power of two, >=2.
- DW, default 32, data width.
- AW, default 5, register-address width.
- SW = log2(DEPTH), derived slot width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alloc_val  in  1  allocate request.
- alloc_rdy  out  1  entry available.
- alloc_wen  in  1  instruction writes a register.
- alloc_waddr  in  AW  destination register.
- alloc_slot  out  SW  slot granted (tail).
- fill_val  in  1  result ready.
- fill_slot  in  SW  slot being filled.
- fill_data  in  DW  result value.
- commit_val  out  1  head ready to retire.
- commit_rdy  in  1  retire accepted.
- commit_wen  out  1  head writes a register.
- commit_waddr  out  AW  head destination.
- commit_data  out  DW  head value.
- flush  in  1  squash all entries.
- srcN_addr  in  AW  lookup address, N=0,1.
- srcN_hit  out  1  in-flight producer exists.
- srcN_pend  out  1  producer not yet filled.
- srcN_slot  out  SW  producer slot.
- srcN_data  out  DW  producer value.
- count  out  SW+1  occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries {valid, filled, wen, waddr, data}, with head/tail pointers of SW+1 bits (MSB is the wrap bit); count = tail-head mod 2*DEPTH.
REQ-004 alloc_rdy SHALL be !full && !flush, combinational and independent of alloc_val; alloc_slot SHALL equal tail[SW-1:0].
REQ-005 Allocate fire (alloc_val&&alloc_rdy) SHALL:
- write entry valid=1, wen=alloc_wen, waddr=alloc_waddr;
- set filled=!alloc_wen, so no-destination entries need no fill;
- increment tail at the edge.
REQ-006 Fill SHALL set filled=1 and data=fill_data at fill_slot on the edge; a fill to an invalid slot or an already-filled slot SHALL be ignored.
REQ-007 commit_val SHALL be valid&&filled of the head entry, derived from registered state only.
- A fill becomes committable no earlier than the next cycle (minimum fill-to-commit_val latency 1).
- commit_wen/waddr/data SHALL be driven 0 when commit_val=0.
REQ-008 Commit fire (commit_val&&commit_rdy) SHALL clear the head valid bit and increment head; at most one commit per cycle.
REQ-009 Simultaneous events:
- Allocate and commit in one cycle SHALL leave count unchanged.
- When full, alloc_rdy stays 0 even if a commit fires that cycle (no pass-through).
- An entry allocated into an empty buffer SHALL NOT commit in the same cycle.
REQ-010 Pointer wrap SHALL be seamless; full/empty SHALL be distinguished by the wrap bit.
REQ-011 Lookup srcN SHALL be combinational:
- Search valid entries with wen=1 and waddr==srcN_addr.
- Select the youngest match, i.e. nearest tail.
- srcN_addr==0 SHALL always miss.
REQ-012 On hit:
- srcN_hit=1, srcN_slot=match slot.
- srcN_pend=!filled, srcN_data=entry data.
- If fill_val targets the matched unfilled slot this cycle: srcN_pend=0, srcN_data=fill_data (fill bypass).
REQ-013 On miss, srcN_hit/pend/slot/data SHALL all be 0.
REQ-014 An entry committing this cycle SHALL still report hit.
REQ-015 Flush SHALL be synchronous, with priority over allocate, fill and commit in the same cycle:
- commit_val forced 0 during flush;
- next cycle: all valid=0, head=tail=0, count=0.

Reset
REQ-016 reset=0 SHALL asynchronously clear all valid bits, head, tail and count; entry data is not reset.
REQ-017 Outputs during and after reset SHALL be: alloc_rdy=1, alloc_slot=0, commit_val=0, commit_wen/waddr/data=0, srcN_*=0, count=0, empty=1, full=0.
REQ-018 A reset asserted mid-operation SHALL discard all in-flight entries without committing any.

Verification
REQ-019 Bench SHALL cover:
- Alloc r3 (slot 0), fill 0xDEAD, commit_rdy=1 -> commit_val next cycle, waddr=3, data=0xDEAD, empty=1 after.
- Alloc r5 twice (slots 0,1), src0_addr=5 -> hit=1, slot=1, pend=1; fill slot 1 with 0x42 same cycle -> pend=0, data=0x42.
- DEPTH=16: 16 allocs -> full=1, alloc_rdy=0; commit one -> alloc_rdy=1 next cycle; 20 further alloc/commit pairs -> wrap, FIFO order preserved.
- Out-of-order fills to slots 2,1,0 -> commits retire in order 0,1,2 only after slot 0 filled.
- Flush with 5 entries plus simultaneous alloc/commit -> no commit, count=0, alloc_slot=0 next cycle.
- reset low mid-stream with 7 entries -> immediate count=0, commit_val=0, empty=1.
